// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: one MAC per cycle over a row-major weight memory.
// Define FC_RELU_EN to clamp negative neuron results to zero before they are registered.
module fc_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FRAC_BITS  = 16,
    parameter int IN_LENGTH  = 16,
    parameter int OUT_LENGTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(IN_LENGTH)-1:0]          in_addr,
    input  logic signed [WIDTH-1:0]               in_data,
    output logic [$clog2(OUT_LENGTH*IN_LENGTH)-1:0] w_addr,
    input  logic signed [WIDTH-1:0]               w_data,
    output logic [$clog2(OUT_LENGTH)-1:0]         b_addr,
    input  logic signed [WIDTH-1:0]               b_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(OUT_LENGTH)-1:0]         out_idx,
    output logic signed [WIDTH-1:0]               out_data
);

    localparam int IW = $clog2(IN_LENGTH);
    localparam int OW = $clog2(OUT_LENGTH);
    localparam int WW = $clog2(OUT_LENGTH * IN_LENGTH);
    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + IW + 1;
    localparam logic [IW-1:0] K_LAST = IW'(IN_LENGTH - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

    state_t                state, state_next;
    logic [OW-1:0]         o_cnt;
    logic [IW-1:0]         k_cnt;
    logic signed [AW-1:0]  acc, acc_next, shifted;
    logic signed [PW-1:0]  prod;
    logic [WIDTH-1:0]      sat;
    logic [WIDTH-1:0]      result;
    logic [WW-1:0]         o_base;
    logic [IW-1:0]         in_addr_q;
    logic [WW-1:0]         w_addr_q;
    logic [OW-1:0]         b_addr_q;

    // Address registers shadow whatever was driven last so the ports hold outside LOAD/MAC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            state     <= state_next;
            in_addr_q <= in_addr;
            w_addr_q  <= w_addr;
            b_addr_q  <= b_addr;
            case (state)
                IDLE: if (start) o_cnt <= '0;
                LOAD: k_cnt <= '0;
                MAC: begin
                    acc   <= acc_next;
                    k_cnt <= k_cnt + IW'(1);
                    if (k_cnt == K_LAST) begin
                        out_data <= result;
                        out_idx  <= o_cnt;
                    end
                end
                OUT: if (out_ready && o_cnt != O_LAST) o_cnt <= o_cnt + OW'(1);
                default: ;
            endcase
        end
    end

    // The last product is folded in combinationally so the result registers as MAC ends.
    always_comb begin
        prod     = PW'(in_data) * PW'(w_data);
        acc_next = acc + AW'(prod);
        if (k_cnt == '0)
            acc_next = (AW'(b_data) <<< FRAC_BITS) + AW'(prod);
        shifted = acc_next >>> FRAC_BITS;
        if ((&shifted[AW-1:WIDTH-1]) || !(|shifted[AW-1:WIDTH-1]))
            sat = shifted[WIDTH-1:0];
        else if (shifted[AW-1])
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sat = {1'b0, {(WIDTH-1){1'b1}}};
`ifdef FC_RELU_EN
        result = sat[WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        out_valid  = 1'b0;
        in_addr    = in_addr_q;
        w_addr     = w_addr_q;
        b_addr     = b_addr_q;
        o_base     = WW'(o_cnt) * WW'(IN_LENGTH);
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                in_addr    = '0;
                w_addr     = o_base;
                b_addr     = o_cnt;
                state_next = MAC;
            end
            MAC: begin
                if (k_cnt == K_LAST) begin
                    state_next = OUT;
                end else begin
                    in_addr = k_cnt + IW'(1);
                    w_addr  = o_base + WW'(k_cnt) + WW'(1);
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = (o_cnt == O_LAST) ? DONE : LOAD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer with a 2-input, 2-neuron Q16.16 layer.
module tb_fc_sequencer;

    localparam int WIDTH   = 32;
    localparam int FRAC    = 16;
    localparam int IN_LEN  = 2;
    localparam int OUT_LEN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, out_valid;
    logic [0:0]  in_addr, b_addr, out_idx;
    logic [1:0]  w_addr;
    logic [31:0] in_data, w_data, b_data, out_data;

    logic [31:0] in_mem [IN_LEN];
    logic [31:0] w_mem  [IN_LEN*OUT_LEN];
    logic [31:0] b_mem  [OUT_LEN];

    int check_count = 0;
    int pass_count  = 0;
    logic [31:0] exp_data [$];
    int          exp_idx  [$];

    fc_sequencer #(
        .WIDTH(WIDTH), .FRAC_BITS(FRAC), .IN_LENGTH(IN_LEN), .OUT_LENGTH(OUT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Reference neuron in wide signed arithmetic, saturated by numeric range.
    function automatic logic [31:0] model(input int o);
        logic signed [127:0] acc, a, w;
        logic signed [31:0]  v;
        logic [31:0]         r;
        v = b_mem[o];
        acc = v;
        acc = acc <<< FRAC;
        for (int i = 0; i < IN_LEN; i++) begin
            v = in_mem[i];
            a = v;
            v = w_mem[o*IN_LEN+i];
            w = v;
            acc = acc + a * w;
        end
        acc = acc >>> FRAC;
        if (acc > 128'sd2147483647)
            r = 32'h7FFFFFFF;
        else if (acc < -128'sd2147483648)
            r = 32'h80000000;
        else
            r = acc[31:0];
`ifdef FC_RELU_EN
        if (r[31]) r = 32'h0;
`endif
        return r;
    endfunction

    task automatic applyStimulus(input logic [31:0] i0, i1, w00, w01, w10, w11, b0, b1);
        in_mem[0] = i0;  in_mem[1] = i1;
        w_mem[0]  = w00; w_mem[1]  = w01;
        w_mem[2]  = w10; w_mem[3]  = w11;
        b_mem[0]  = b0;  b_mem[1]  = b1;
        for (int o = 0; o < OUT_LEN; o++) begin
            exp_idx.push_back(o);
            exp_data.push_back(model(o));
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checkOutput("sb_pending", 32'(exp_data.size() > 0), 32'd1);
            if (exp_data.size() > 0) begin
                checkOutput("out_idx", 32'(out_idx), 32'(exp_idx.pop_front()));
                checkOutput("out_data", out_data, exp_data.pop_front());
            end
        end
    end

    // Entry and exit at #1 after a rising edge; cycle 1 is the first cycle after start is sampled.
    task automatic runLayer(input int stall, input int exp_lat, input bit hold_start, input string name);
        int          cyc;
        int          stalled;
        bit          seen;
        logic [31:0] held_data, held_idx;
        out_ready = (stall == 0);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cyc = 1; stalled = 0; seen = 1'b0; held_data = '0; held_idx = '0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (out_valid && !out_ready) begin
                    if (stalled == 0) begin
                        held_data = out_data;
                        held_idx  = 32'(out_idx);
                    end else begin
                        checkOutput({name, "_stall_data"}, out_data, held_data);
                        checkOutput({name, "_stall_idx"}, 32'(out_idx), held_idx);
                    end
                    stalled++;
                end
                @(posedge clk); #1;
                cyc++;
                if (stalled >= stall) out_ready = 1'b1;
            end
        end
        checkOutput({name, "_done_latency"}, 32'(cyc), 32'(exp_lat));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_sb_drained"}, 32'(exp_data.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] randWord(input bit full);
        logic signed [31:0] v;
        if (full) begin
            v = $urandom;
        end else begin
            v = $urandom_range(0, 32'h0007FFFF);
            v = v - 32'sh00040000;
        end
        return v;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int saw;
        for (int i = 0; i < IN_LEN; i++) in_mem[i] = '0;
        for (int i = 0; i < IN_LEN*OUT_LEN; i++) w_mem[i] = '0;
        for (int i = 0; i < OUT_LEN; i++) b_mem[i] = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_in_addr", 32'(in_addr), 32'd0);
        checkOutput("rst_w_addr", 32'(w_addr), 32'd0);
        checkOutput("rst_b_addr", 32'(b_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        runLayer(0, 9, 1'b0, "basic");

        applyStimulus(32'h00010000, 32'h0, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        runLayer(0, 9, 1'b0, "negative");

        applyStimulus(32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        runLayer(5, 14, 1'b0, "stall");

        applyStimulus(32'h75300000, 32'h75300000, 32'h75300000, 32'h75300000,
                      32'h8AD00000, 32'h8AD00000, 32'h0, 32'h0);
        runLayer(0, 9, 1'b0, "saturate");

        // Reset during MAC step 1 must abandon the evaluation entirely.
        applyStimulus(32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_idx.delete();
        exp_data.delete();
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", out_data, 32'd0);
        checkOutput("midrst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("midrst_in_addr", 32'(in_addr), 32'd0);
        checkOutput("midrst_w_addr", 32'(w_addr), 32'd0);
        checkOutput("midrst_b_addr", 32'(b_addr), 32'd0);
        saw = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || out_valid || busy) saw++;
        end
        checkOutput("midrst_quiet", 32'(saw), 32'd0);
        @(posedge clk); #1;

        applyStimulus(32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        runLayer(0, 9, 1'b0, "post_reset");

        applyStimulus(32'h00010000, 32'h00020000, 32'h00008000, 32'h00004000,
                      32'hFFFE8000, 32'h0, 32'h00010000, 32'h0);
        runLayer(0, 9, 1'b1, "hold_start");

        for (int r = 0; r < 6; r++) begin
            bit full;
            full = (r >= 4);
            applyStimulus(randWord(full), randWord(full), randWord(full), randWord(full),
                          randWord(full), randWord(full), randWord(full), randWord(full));
            runLayer(0, 9, 1'b0, "random");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data word width; FRAC_BITS, default 16, fractional bits of the signed fixed-point format; IN_LENGTH, default 16, inputs per neuron; OUT_LENGTH, default 16, neurons per layer.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin one layer evaluation
- busy  out  1  evaluation in progress
- done  out  1  one-cycle completion pulse
- in_addr  out  $clog2(IN_LENGTH)  input-vector read address
- in_data  in  WIDTH  signed input word, 1-cycle read latency
- w_addr  out  $clog2(OUT_LENGTH*IN_LENGTH)  weight address, row-major o*IN_LENGTH+i
- w_data  in  WIDTH  signed weight word, 1-cycle read latency
- b_addr  out  $clog2(OUT_LENGTH)  bias address
- b_data  in  WIDTH  signed bias word, 1-cycle read latency
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_idx  out  $clog2(OUT_LENGTH)  neuron index of out_data
- out_data  out  WIDTH  signed neuron result

Function
REQ-004 The block SHALL compute out[o] = bias[o] + sum over i of in[i]*w[o][i] for o = 0..OUT_LENGTH-1, in order, using one multiplier.
REQ-005 The FSM SHALL have states IDLE, LOAD, MAC, OUT and DONE.
REQ-006 IDLE: start high SHALL move to LOAD with o=0; busy is high in every state except IDLE.
REQ-007 LOAD (1 cycle): drive b_addr=o, in_addr=0, w_addr=o*IN_LENGTH, set i=0, then go to MAC.
REQ-008 MAC (IN_LENGTH cycles, step k):
- data for element k is present;
- step 0: acc = (b_data <<< FRAC_BITS) + in_data*w_data;
- steps k>0: acc += in_data*w_data;
- addresses for element k+1 are driven in the same cycle;
- go to OUT after k = IN_LENGTH-1.
REQ-009 Accumulator width SHALL be 2*WIDTH+$clog2(IN_LENGTH)+1 bits, signed, so there is no internal overflow.
REQ-010 Result SHALL be acc arithmetically shifted right by FRAC_BITS (floor), then saturated to the signed WIDTH range.
REQ-011 OUT: out_valid=1, with out_data and out_idx=o held stable until out_ready is high.
- On handshake: if o = OUT_LENGTH-1, go to DONE; else o++ and go to LOAD.
REQ-012 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-013 start SHALL be ignored in every state except IDLE.
REQ-014 With out_ready tied high, done SHALL assert OUT_LENGTH*(IN_LENGTH+2)+1 cycles after the cycle in which start is sampled; each out_ready-low OUT cycle adds one cycle.
REQ-015 Outside LOAD/MAC, address outputs SHALL hold their last value; in IDLE, out_valid=0.

Reset
REQ-016 rst_n low at a clock edge SHALL force IDLE and clear:
- busy, done and out_valid to 0;
- out_data, out_idx and all addresses to 0;
- acc and all counters to 0.
REQ-017 Reset in any state, including mid-MAC or in OUT, SHALL discard the partial evaluation; no out_valid or done follows until a new start.

Configuration
REQ-018 Macro FC_RELU_EN: when defined, the saturated result SHALL be clamped so that negative values become 0 before out_data is registered.
- When undefined, signed results pass unchanged.
- Timing is identical in both builds.

Verification
REQ-019 IN=2, OUT=2, Q16.16, in={0x00010000,0x00020000}, w row0={0x00008000,0x00004000}, bias0=0x00010000, out_ready=1 -> out_idx 0, out_data 0x00020000; done in cycle 9 after start.
REQ-020 in={0x00010000,0}, w row1={0xFFFE8000,0}, bias1=0 -> out_data 0xFFFE8000 without FC_RELU_EN; 0x00000000 with it.
REQ-021 in={0x75300000,0x75300000} (30000.0), w={0x75300000,0x75300000}, bias 0 -> out_data 0x7FFFFFFF; negate one operand of each product -> 0x80000000 (macro undefined).
REQ-022 out_ready low for 5 cycles in first OUT -> out_valid, out_data and out_idx stable for 5 cycles; done arrives 5 cycles later than in REQ-019.
REQ-023 rst_n low for one cycle during MAC step 1 -> all outputs 0 next cycle, no done; a following start reproduces the REQ-019 results exactly.
REQ-024 start pulsed during MAC and held high through DONE -> second start is ignored while busy; a new evaluation begins only from IDLE.
